// File: rtl/issue_queue_2w_if.sv
// Issue-queue bus interface: decode pushes up to two entries, issue pops up to two.
//   master : decode/issue side, drives in_entry, in_valid, pop_cnt
//   slave  : the queue, drives out_entry, out_valid, full, empty, count
interface issue_queue_2w_if #(
  parameter int unsigned ENTRY_W = 128,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
);
  logic [2*ENTRY_W-1:0] in_entry;
  logic [1:0]           in_valid;
  logic [1:0]           pop_cnt;
  logic [2*ENTRY_W-1:0] out_entry;
  logic [1:0]           out_valid;
  logic                 full;
  logic                 empty;
  logic [CNT_W-1:0]     count;

  modport master (
    output in_entry, in_valid, pop_cnt,
    input  out_entry, out_valid, full, empty, count
  );

  modport slave (
    input  in_entry, in_valid, pop_cnt,
    output out_entry, out_valid, full, empty, count
  );
endinterface

// File: rtl/issue_queue_2w.sv
// Dual-write, dual-read circular instruction queue between decode and issue.
// Ports:
//   clk    : core clock, all state updates on posedge
//   reset  : synchronous active-high reset (head/tail/count cleared, array kept)
//   flush  : discard all contents this cycle; push/pop of that cycle ignored
//   q_if   : slave side of issue_queue_2w_if
//            in_entry/in_valid : two decoded slots, slot 0 older
//            pop_cnt           : entries consumed by issue (3 treated as 2)
//            out_entry/out_valid : head in slot 0, head+1 in slot 1
//            full/empty/count  : occupancy status from registered count
module issue_queue_2w #(
  parameter int unsigned ENTRY_W = 128,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  issue_queue_2w_if.slave   q_if
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [PTR_W-1:0]   head_p1_c;
  logic [PTR_W-1:0]   tail_p1_c;
  logic [ENTRY_W-1:0] slot0_c, slot1_c;
  logic               full_c;
  logic [1:0]         push_n_c;
  logic [1:0]         pop_req_c;
  logic [1:0]         pop_n_c;
  logic               wr0_en_c, wr1_en_c;
  logic [ENTRY_W-1:0] wr0_data_c, wr1_data_c;

  assign head_p1_c = head_q + PTR_W'(1);
  assign tail_p1_c = tail_q + PTR_W'(1);
  assign slot0_c   = q_if.in_entry[ENTRY_W-1:0];
  assign slot1_c   = q_if.in_entry[2*ENTRY_W-1:ENTRY_W];

  // Conservative full: fewer than two free slots, from the registered count only.
  assign full_c = (count_q > CNT_W'(DEPTH - 2));

  // Push compaction: valid slots land at tail, tail+1 in slot order.
  always_comb begin
    wr0_en_c   = 1'b0;
    wr1_en_c   = 1'b0;
    wr0_data_c = slot0_c;
    wr1_data_c = slot1_c;
    push_n_c   = 2'd0;
    if (!full_c && !flush) begin
      unique case (q_if.in_valid)
        2'b01: begin
          wr0_en_c = 1'b1;
          push_n_c = 2'd1;
        end
        2'b10: begin
          wr0_en_c   = 1'b1;
          wr0_data_c = slot1_c;
          push_n_c   = 2'd1;
        end
        2'b11: begin
          wr0_en_c = 1'b1;
          wr1_en_c = 1'b1;
          push_n_c = 2'd2;
        end
        default: ;
      endcase
    end
  end

  // Pop amount: pop_cnt=3 clamps to 2, then saturates at current occupancy.
  always_comb begin
    pop_req_c = (q_if.pop_cnt == 2'd3) ? 2'd2 : q_if.pop_cnt;
    pop_n_c   = pop_req_c;
    if (CNT_W'(pop_req_c) > count_q) begin
      pop_n_c = count_q[1:0];
    end
  end

  // Next pointer/count state; flush overrides any push or pop this cycle.
  always_comb begin
    head_d  = head_q + PTR_W'(pop_n_c);
    tail_d  = tail_q + PTR_W'(push_n_c);
    count_d = count_q + CNT_W'(push_n_c) - CNT_W'(pop_n_c);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; writes use the pre-update tail.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr0_en_c) mem_q[tail_q]    <= wr0_data_c;
      if (wr1_en_c) mem_q[tail_p1_c] <= wr1_data_c;
    end
  end

  assign q_if.out_entry = {mem_q[head_p1_c], mem_q[head_q]};
  assign q_if.out_valid = {(count_q >= CNT_W'(2)), (count_q != '0)};
  assign q_if.full      = full_c;
  assign q_if.empty     = (count_q == '0);
  assign q_if.count     = count_q;

endmodule

// File: tb/tb_issue_queue_2w.sv
// Directed bench for issue_queue_2w at DEPTH=8.
module tb_issue_queue_2w;

  localparam int unsigned ENTRY_W = 128;
  localparam int unsigned DEPTH   = 8;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  int n_checks = 0;
  int n_pass   = 0;

  issue_queue_2w_if #(.ENTRY_W(ENTRY_W), .DEPTH(DEPTH)) q_if ();

  issue_queue_2w #(.ENTRY_W(ENTRY_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .q_if  (q_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_checks++;
    if (obs !== exp_v) $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    else n_pass++;
  endtask

  function automatic logic [255:0] pair(input logic [127:0] s0, input logic [127:0] s1);
    return {s1, s0};
  endfunction

  // One clock with the given push/pop request, outputs sampled 1 after the edge.
  task automatic cyc(input logic [1:0] v, input logic [127:0] e0, input logic [127:0] e1,
                     input logic [1:0] pc);
    q_if.in_valid = v;
    q_if.in_entry = {e1, e0};
    q_if.pop_cnt  = pc;
    @(posedge clk);
    #1;
    q_if.in_valid = 2'b00;
    q_if.pop_cnt  = 2'd0;
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic [1:0] ov,
                           input logic fl, input logic em);
    check({tag, "_count"}, 256'(q_if.count), 256'(cnt));
    check({tag, "_ovalid"}, 256'(q_if.out_valid), 256'(ov));
    check({tag, "_full"}, 256'(q_if.full), 256'(fl));
    check({tag, "_empty"}, 256'(q_if.empty), 256'(em));
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    q_if.in_valid = 2'b00;
    q_if.in_entry = '0;
    q_if.pop_cnt  = 2'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_state("reset", 0, 2'b00, 1'b0, 1'b1);

    // First dual push, visible next cycle
    cyc(2'b11, 128'hA, 128'hB, 2'd0);
    chk_state("push_ab", 2, 2'b11, 1'b0, 1'b0);
    check("push_ab_data", q_if.out_entry, pair(128'hA, 128'hB));

    // Fill to DEPTH; push while full is dropped
    cyc(2'b11, 128'h102, 128'h103, 2'd0);
    cyc(2'b11, 128'h104, 128'h105, 2'd0);
    chk_state("cnt6", 6, 2'b11, 1'b0, 1'b0);
    cyc(2'b11, 128'h106, 128'h107, 2'd0);
    chk_state("cnt8", 8, 2'b11, 1'b1, 1'b0);
    cyc(2'b11, 128'hDEAD, 128'hBEEF, 2'd0);
    chk_state("full_push", 8, 2'b11, 1'b1, 1'b0);
    check("full_push_data", q_if.out_entry, pair(128'hA, 128'hB));
    cyc(2'b00, '0, '0, 2'd2);
    check("drain1", q_if.out_entry, pair(128'h102, 128'h103));
    cyc(2'b00, '0, '0, 2'd2);
    check("drain2", q_if.out_entry, pair(128'h104, 128'h105));
    cyc(2'b00, '0, '0, 2'd2);
    check("drain3", q_if.out_entry, pair(128'h106, 128'h107));
    cyc(2'b00, '0, '0, 2'd2);
    chk_state("drained", 0, 2'b00, 1'b0, 1'b1);

    // Push at count=6 accepted alongside a pop; at count=7 full blocks the push
    cyc(2'b11, 128'h200, 128'h201, 2'd0);
    cyc(2'b11, 128'h202, 128'h203, 2'd0);
    cyc(2'b11, 128'h204, 128'h205, 2'd0);
    chk_state("fill6", 6, 2'b11, 1'b0, 1'b0);
    cyc(2'b11, 128'h206, 128'h207, 2'd1);
    chk_state("pushpop6", 7, 2'b11, 1'b1, 1'b0);
    check("pushpop6_data", q_if.out_entry, pair(128'h201, 128'h202));
    cyc(2'b11, 128'h2AA, 128'h2BB, 2'd1);
    chk_state("pushpop7", 6, 2'b11, 1'b0, 1'b0);
    check("pushpop7_data", q_if.out_entry, pair(128'h202, 128'h203));
    cyc(2'b00, '0, '0, 2'd2);
    check("d2_a", q_if.out_entry, pair(128'h204, 128'h205));
    cyc(2'b00, '0, '0, 2'd2);
    check("d2_b", q_if.out_entry, pair(128'h206, 128'h207));
    check("d2_b_count", 256'(q_if.count), 256'(2));
    cyc(2'b00, '0, '0, 2'd2);
    chk_state("d2_empty", 0, 2'b00, 1'b0, 1'b1);

    // Walk head/tail to 7 with the queue empty
    cyc(2'b11, 128'h300, 128'h301, 2'd0);
    cyc(2'b11, 128'h302, 128'h303, 2'd0);
    cyc(2'b11, 128'h304, 128'h305, 2'd0);
    cyc(2'b01, 128'h306, 128'h0, 2'd0);
    chk_state("cnt7", 7, 2'b11, 1'b1, 1'b0);
    cyc(2'b00, '0, '0, 2'd2);
    cyc(2'b00, '0, '0, 2'd2);
    cyc(2'b00, '0, '0, 2'd2);
    check("last_one", q_if.out_entry[127:0], 256'h306);
    cyc(2'b00, '0, '0, 2'd1);
    chk_state("at7", 0, 2'b00, 1'b0, 1'b1);

    // Wrap: C at index 7, D at index 0
    cyc(2'b11, 128'hC, 128'hD, 2'd0);
    chk_state("wrap", 2, 2'b11, 1'b0, 1'b0);
    check("wrap_data", q_if.out_entry, pair(128'hC, 128'hD));
    cyc(2'b00, '0, '0, 2'd2);
    chk_state("wrap_pop", 0, 2'b00, 1'b0, 1'b1);

    // Pop on empty and pop_cnt=3 never underflow
    cyc(2'b00, '0, '0, 2'd2);
    check("pop_empty", 256'(q_if.count), 256'(0));
    cyc(2'b11, 128'h71, 128'h72, 2'd0);
    check("pre_pop3", q_if.out_entry, pair(128'h71, 128'h72));
    cyc(2'b00, '0, '0, 2'd3);
    chk_state("pop3", 0, 2'b00, 1'b0, 1'b1);

    // count=1, pop 2 with slot-1-only push of E
    cyc(2'b01, 128'hF, 128'h0, 2'd0);
    chk_state("one", 1, 2'b01, 1'b0, 1'b0);
    check("one_data", q_if.out_entry[127:0], 256'hF);
    cyc(2'b10, 128'h999, 128'hE, 2'd2);
    chk_state("sat_pop", 1, 2'b01, 1'b0, 1'b0);
    check("sat_pop_data", q_if.out_entry[127:0], 256'hE);

    // Flush with push and pop pending
    cyc(2'b11, 128'h81, 128'h82, 2'd0);
    cyc(2'b11, 128'h83, 128'h84, 2'd0);
    chk_state("cnt5", 5, 2'b11, 1'b0, 1'b0);
    flush = 1'b1;
    cyc(2'b11, 128'h91, 128'h92, 2'd2);
    flush = 1'b0;
    chk_state("flush", 0, 2'b00, 1'b0, 1'b1);
    cyc(2'b11, 128'hA1, 128'hA2, 2'd0);
    chk_state("post_flush", 2, 2'b11, 1'b0, 1'b0);
    check("post_flush_data", q_if.out_entry, pair(128'hA1, 128'hA2));

    // Reset together with flush mid-operation
    cyc(2'b11, 128'hB1, 128'hB2, 2'd0);
    check("pre_rst", 256'(q_if.count), 256'(4));
    reset = 1'b1;
    flush = 1'b1;
    cyc(2'b11, 128'hC1, 128'hC2, 2'd1);
    reset = 1'b0;
    flush = 1'b0;
    chk_state("rst_flush", 0, 2'b00, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
